// File: rtl/fpga_lvds_pkg.sv
// Shared types and defaults for the differential serial receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the link is free-running with no flow control.
package fpga_lvds_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lvds_rx_state_t;

    // Alignment token; mixed ones and zeros so idle all-0/all-1 lines never lock.
    localparam logic [9:0] LVDS_SYNC_WORD = 10'h354;
    localparam int         LVDS_SYNC_TMO  = 16;

endpackage

// File: rtl/fpga_ilvds.sv
// Differential input buffer: pad pair to one single-ended bit (TMDS_33, on-die termination).
// Latency: combinational, zero cycles.
// Backpressure: none; the pad value is passed straight through.
// Ports: i_p / i_n differential legs in, o_bit single-ended bit out.
module fpga_ilvds (
    input  logic i_p,
    input  logic i_n,
    output logic o_bit
);

`ifdef FPGA_ILVDS_USE_IBUFDS
    IBUFDS #(
        .IOSTANDARD ("TMDS_33"),
        .DIFF_TERM  ("TRUE")
    ) u_ibufds (
        .I  (i_p),
        .IB (i_n),
        .O  (o_bit)
    );
`else
    // Behavioural stand-in: a valid differential '1' is p high with n low.
    assign o_bit = i_p & ~i_n;
`endif

endmodule

// File: rtl/fpga_ilvds_rx.sv
// Differential serial receiver: pad buffer, IOB flop, W-bit deserializer, SYNC_WORD alignment.
// Latency: a bit sampled at edge t completes its word on o_data after edge t+2.
// Backpressure: none; o_vld is a one-cycle strobe the link layer must take every time.
// Ports: clk/arst_n; i_p/i_n pad pair; en receiver enable;
//        o_data/o_vld/o_sync aligned word stream; o_locked lock state; o_err_cnt lock-loss count.
module fpga_ilvds_rx
    import fpga_lvds_pkg::*;
#(
    parameter int             W         = 10,
    parameter logic [W-1:0]   SYNC_WORD = W'(LVDS_SYNC_WORD),
    parameter int             SYNC_TMO  = LVDS_SYNC_TMO,
    parameter int             ERR_W     = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_p,
    input  logic             i_n,
    input  logic             en,
    output logic [W-1:0]     o_data,
    output logic             o_vld,
    output logic             o_sync,
    output logic             o_locked,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam int BCW = $clog2(W);

    logic           rx_bit;
    logic           rx_q;
    logic [W-1:0]   sh;
    lvds_rx_state_t state;
    logic [BCW-1:0] bit_cnt;
    logic [7:0]     wd_cnt;
    logic           sh_is_sync;
    logic           word_end;
    logic           tmo_hit;

    fpga_ilvds u_ilvds (
        .i_p   (i_p),
        .i_n   (i_n),
        .o_bit (rx_bit)
    );

    assign sh_is_sync = (sh == SYNC_WORD);
    assign word_end   = (bit_cnt == BCW'(W - 1));
    // Last word allowed without a SYNC_WORD before the lock is declared lost.
    assign tmo_hit    = (wd_cnt == 8'(SYNC_TMO - 1));
    assign o_locked   = (state == LOCKED);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_q      <= 1'b0;
            sh        <= '0;
            state     <= HUNT;
            bit_cnt   <= '0;
            wd_cnt    <= '0;
            o_data    <= '0;
            o_vld     <= 1'b0;
            o_sync    <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            rx_q   <= rx_bit;
            // LSB arrives first, so new bits enter at the MSB and age toward bit 0.
            sh     <= {rx_q, sh[W-1:1]};
            o_vld  <= 1'b0;
            o_sync <= 1'b0;

            if (!en) begin
                // Disable takes priority over a coincident timeout and is not an error.
                state   <= HUNT;
                bit_cnt <= '0;
                wd_cnt  <= '0;
            end else if (state == HUNT) begin
                if (sh_is_sync) begin
                    state   <= LOCKED;
                    bit_cnt <= '0;
                    wd_cnt  <= '0;
                    o_data  <= sh;
                    o_vld   <= 1'b1;
                    o_sync  <= 1'b1;
                end
            end else if (word_end) begin
                bit_cnt <= '0;
                o_data  <= sh;
                o_vld   <= 1'b1;
                o_sync  <= sh_is_sync;
                if (sh_is_sync) begin
                    wd_cnt <= '0;
                end else if (tmo_hit) begin
                    state  <= HUNT;
                    wd_cnt <= '0;
                    if (o_err_cnt != {ERR_W{1'b1}}) begin
                        o_err_cnt <= o_err_cnt + ERR_W'(1);
                    end
                end else begin
                    wd_cnt <= wd_cnt + 8'd1;
                end
            end else begin
                // Off-boundary SYNC_WORD patterns are deliberately ignored here.
                bit_cnt <= bit_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpga_ilvds_rx.sv
`timescale 1ns/1ps
module tb_fpga_ilvds_rx;

    localparam int           W    = 10;
    localparam logic [W-1:0] SYNC = 10'h354;
    localparam int           TMO  = 16;
    localparam int           NB   = 65536;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         i_p, i_n, en;
    logic [W-1:0] o_data;
    logic         o_vld, o_sync, o_locked;
    logic [7:0]   o_err_cnt;

    fpga_ilvds_rx #(.W(W), .SYNC_WORD(SYNC), .SYNC_TMO(TMO), .ERR_W(8)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_p       (i_p),
        .i_n       (i_n),
        .en        (en),
        .o_data    (o_data),
        .o_vld     (o_vld),
        .o_sync    (o_sync),
        .o_locked  (o_locked),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;

    // Reference model: the received bit stream indexed by clock edge, plus
    // lock bookkeeping expressed in bit positions of word boundaries.
    bit           bits [NB];
    int           edge_n;
    bit           m_locked;
    int           anchor;      // bit index ending the word that produced lock
    int           last_sync;   // bit index ending the most recent aligned SYNC
    int           m_err;
    logic [W-1:0] m_data;
    bit           m_vld, m_sync;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] window(input int j);
        logic [W-1:0] w;
        for (int k = 0; k < W; k++) w[k] = bits[j - W + 1 + k];
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NB; k++) bits[k] = 1'b0;
        m_locked = 1'b0;
        anchor = 0;
        last_sync = 0;
        m_err = 0;
        m_data = '0;
        m_vld = 1'b0;
        m_sync = 1'b0;
    endtask

    // The word whose last bit was sampled two edges ago is what this edge decides on.
    task automatic model_step(input bit e);
        int           j;
        logic [W-1:0] win;
        bit           emit;
        j = edge_n - 2;
        win = window(j);
        emit = 1'b0;
        if (!e) begin
            m_locked = 1'b0;
        end else if (!m_locked) begin
            if (win == SYNC) begin
                m_locked = 1'b1;
                anchor = j;
                last_sync = j;
                emit = 1'b1;
            end
        end else if (((j - anchor) % W) == 0) begin
            emit = 1'b1;
            if (win == SYNC) begin
                last_sync = j;
            end else if ((j - last_sync) / W >= TMO) begin
                m_locked = 1'b0;
                if (m_err < 255) m_err++;
            end
        end
        m_vld  = emit;
        m_sync = emit && (win == SYNC);
        if (emit) m_data = win;
    endtask

    task automatic tick(input logic b);
        bit e;
        i_p = b;
        i_n = ~b;
        e = en;
        @(posedge clk);
        edge_n++;
        bits[edge_n] = b;
        #1;
        model_step(e);
        chk("vld",    32'(o_vld),     32'(m_vld));
        chk("sync",   32'(o_sync),    32'(m_sync));
        chk("locked", 32'(o_locked),  32'(m_locked));
        chk("errcnt", 32'(o_err_cnt), 32'(m_err));
        chk("data",   32'(o_data),    32'(m_data));
        if (o_vld) vcnt++;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) tick(w[k]);
    endtask

    // Data words with no two adjacent ones can never form SYNC_WORD at any phase.
    function automatic logic [W-1:0] sparse_word();
        return W'($urandom) & 10'h155;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] r;
        arst_n = 1'b0;
        en = 1'b0;
        i_p = 1'b0;
        i_n = 1'b1;
        edge_n = 20;
        model_reset();
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        #1;
        chk("rst_data",   32'(o_data),    32'h0);
        chk("rst_vld",    32'(o_vld),     32'h0);
        chk("rst_sync",   32'(o_sync),    32'h0);
        chk("rst_locked", 32'(o_locked),  32'h0);
        chk("rst_err",    32'(o_err_cnt), 32'h0);

        // 1: random lead-in (shaped so it cannot alias a SYNC prefix), then SYNC stream.
        en = 1'b1;
        r = 7'($urandom);
        r[6] = 1'b1;
        r[5] = 1'b0;
        for (int k = 0; k < 7; k++) tick(r[k]);
        repeat (5) send_word(SYNC);
        chk("t1_locked", 32'(o_locked), 32'h1);

        // 2: SYNC, 15 data words, SYNC keeps lock with 17 strobes.
        vcnt = 0;
        send_word(SYNC);
        for (int k = 0; k < 15; k++) send_word(10'h0AA + W'(k));
        send_word(SYNC);
        chk("t2_vld_cnt", 32'(vcnt),      32'd17);
        chk("t2_err",     32'(o_err_cnt), 32'h0);
        chk("t2_locked",  32'(o_locked),  32'h1);

        // 3: 16 non-SYNC words time out; the 16th strobe lands 2 bits into the next word.
        for (int k = 0; k < TMO; k++) send_word(sparse_word());
        tick(SYNC[0]);
        tick(SYNC[1]);
        chk("t3_unlocked", 32'(o_locked),  32'h0);
        chk("t3_err",      32'(o_err_cnt), 32'h1);
        for (int k = 2; k < W; k++) tick(SYNC[k]);
        send_word(SYNC);
        chk("t3_relock", 32'(o_locked), 32'h1);

        // 4: one slipped bit; lock lost after the timeout, then relock on the new phase.
        tick(1'b0);
        repeat (20) send_word(SYNC);
        chk("t4_relock", 32'(o_locked),  32'h1);
        chk("t4_err",    32'(o_err_cnt), 32'h2);

        // 5: enable dropped for 3 cycles mid-word.
        for (int k = 0; k < 4; k++) tick(SYNC[k]);
        en = 1'b0;
        tick(SYNC[4]);
        chk("t5_unlocked", 32'(o_locked),  32'h0);
        tick(SYNC[5]);
        tick(SYNC[6]);
        en = 1'b1;
        for (int k = 7; k < W; k++) tick(SYNC[k]);
        chk("t5_err", 32'(o_err_cnt), 32'h2);
        repeat (3) send_word(SYNC);
        chk("t5_relock", 32'(o_locked), 32'h1);

        // 6: saturate the lock-loss counter.
        for (int n = 0; n < 270; n++) begin
            send_word(SYNC);
            for (int k = 0; k < TMO; k++) send_word(sparse_word());
        end
        chk("t6_sat", 32'(o_err_cnt), 32'hFF);

        // Asynchronous reset mid-word.
        send_word(SYNC);
        for (int k = 0; k < 5; k++) tick(SYNC[k]);
        arst_n = 1'b0;
        #2;
        chk("ar_data",   32'(o_data),    32'h0);
        chk("ar_vld",    32'(o_vld),     32'h0);
        chk("ar_sync",   32'(o_sync),    32'h0);
        chk("ar_locked", 32'(o_locked),  32'h0);
        chk("ar_err",    32'(o_err_cnt), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (4) send_word(SYNC);
        chk("ar_relock", 32'(o_locked),  32'h1);
        chk("ar_err2",   32'(o_err_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
